// File: rtl/systolic_skew_feeder.sv
// Skewed tile feeder for pe_8x8_cluster: buffers one tile per row lane and
// streams it diagonally (lane i delayed i cycles), with per-lane done flags.
//
// Optional feature macro: SKEW_FEEDER_OVERRUN_EN (sticky wr_err detection).
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   en              : global enable, 0 freezes all state
//   wr_en/wr_lane/wr_idx/wr_act/wr_wgt : buffer write port (IDLE only)
//   len, start      : tile length (clamped to DEPTH) and stream start
//   array_done      : cluster completion, releases WAIT
//   activations/weights : lane i at [i*DW +: DW], registered
//   done            : per-lane end-of-stream level
//   busy            : high in FEED or WAIT
//   wr_err          : sticky overrun flag (0 unless macro defined)
module systolic_skew_feeder #(
    parameter int LANES = 8,
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      wr_en,
    input  logic [$clog2(LANES)-1:0]  wr_lane,
    input  logic [3:0]                wr_idx,
    input  logic [DW-1:0]             wr_act,
    input  logic [DW-1:0]             wr_wgt,
    input  logic [3:0]                len,
    input  logic                      start,
    input  logic                      array_done,
    output logic [LANES*DW-1:0]       activations,
    output logic [LANES*DW-1:0]       weights,
    output logic [LANES-1:0]          done,
    output logic                      busy,
    output logic                      wr_err
);

    localparam int LW = $clog2(LANES);
    // counter must reach LANES-1+15
    localparam int CW = $clog2(LANES + 16);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [3:0]            len_q, len_d;
    logic [LANES*DW-1:0]   act_q, act_d;
    logic [LANES*DW-1:0]   wgt_q, wgt_d;
    logic [LANES-1:0]      done_q, done_d;
    logic                  busy_q, busy_d;

    logic [DW-1:0]         act_mem_q [LANES][DEPTH];
    logic [DW-1:0]         act_mem_d [LANES][DEPTH];
    logic [DW-1:0]         wgt_mem_q [LANES][DEPTH];
    logic [DW-1:0]         wgt_mem_d [LANES][DEPTH];

    logic                  wr_ok;

    // buffers only change in IDLE; out-of-range indices simply match nothing
    assign wr_ok = en && !rst && wr_en && (state_q == S_IDLE);

    always_comb begin
        act_mem_d = act_mem_q;
        wgt_mem_d = wgt_mem_q;
        for (int i = 0; i < LANES; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (wr_ok && wr_lane == LW'(i) && wr_idx == 4'(k)) begin
                    act_mem_d[i][k] = wr_act;
                    wgt_mem_d[i][k] = wr_wgt;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        act_mem_q <= act_mem_d;
        wgt_mem_q <= wgt_mem_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        act_d   = act_q;
        wgt_d   = wgt_q;
        done_d  = done_q;
        busy_d  = busy_q;
        if (en) begin
            unique case (state_q)
                S_IDLE: begin
                    act_d = '0;
                    wgt_d = '0;
                    if (start) begin
                        len_d   = (len > 4'(DEPTH)) ? 4'(DEPTH) : len;
                        cnt_d   = '0;
                        done_d  = '0;
                        busy_d  = 1'b1;
                        state_d = S_FEED;
                    end
                end
                S_FEED: begin
                    act_d = '0;
                    wgt_d = '0;
                    // lane i shows element k when cnt == i+k
                    for (int i = 0; i < LANES; i++) begin
                        for (int k = 0; k < DEPTH; k++) begin
                            if (4'(k) < len_q && cnt_q == CW'(i + k)) begin
                                act_d[i*DW +: DW] = act_mem_q[i][k];
                                wgt_d[i*DW +: DW] = wgt_mem_q[i][k];
                            end
                        end
                        if (cnt_q == CW'(i) + CW'(len_q)) begin
                            done_d[i] = 1'b1;
                        end
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (done_d[LANES-1]) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    act_d = '0;
                    wgt_d = '0;
                    if (array_done) begin
                        done_d  = '0;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            act_q   <= '0;
            wgt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            act_q   <= act_d;
            wgt_q   <= wgt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign activations = act_q;
    assign weights     = wgt_q;
    assign done        = done_q;
    assign busy        = busy_q;

`ifdef SKEW_FEEDER_OVERRUN_EN
    logic wr_err_q, wr_err_d;

    always_comb begin
        wr_err_d = wr_err_q;
        if (en && wr_en &&
            (state_q != S_IDLE || wr_idx >= 4'(DEPTH))) begin
            wr_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_err_d;
        end
    end

    assign wr_err = wr_err_q;
`else
    assign wr_err = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Randomized bench for systolic_skew_feeder against a cycle-count model.
// Expected streams are derived from edges elapsed since start.
module tb_systolic_skew_feeder;

    localparam int LANES = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int BW    = LANES * DW;

    logic              clk = 1'b0;
    logic              rst, en, wr_en, start, array_done;
    logic [2:0]        wr_lane;
    logic [3:0]        wr_idx, len;
    logic [DW-1:0]     wr_act, wr_wgt;
    logic [BW-1:0]     activations, weights;
    logic [LANES-1:0]  done;
    logic              busy, wr_err;

    always #5 clk = ~clk;

    systolic_skew_feeder #(
        .LANES (LANES),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .wr_en       (wr_en),
        .wr_lane     (wr_lane),
        .wr_idx      (wr_idx),
        .wr_act      (wr_act),
        .wr_wgt      (wr_wgt),
        .len         (len),
        .start       (start),
        .array_done  (array_done),
        .activations (activations),
        .weights     (weights),
        .done        (done),
        .busy        (busy),
        .wr_err      (wr_err)
    );

    // model: buffers plus "edges since start" view of a tile
    logic [DW-1:0] m_act [LANES][DEPTH];
    logic [DW-1:0] m_wgt [LANES][DEPTH];
    int            m_run;
    int            m_n;
    int            m_len;
    bit            m_err;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag,
                       input logic [BW-1:0] obs,
                       input logic [BW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got %h want %h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_edge();
        int li, ki;
        li = int'(wr_lane);
        ki = int'(wr_idx);
        if (rst) begin
            m_run = 0;
            m_err = 1'b0;
        end else if (en) begin
            if (m_run == 0) begin
                if (wr_en) begin
                    if (ki < DEPTH) begin
                        m_act[li][ki] = wr_act;
                        m_wgt[li][ki] = wr_wgt;
                    end else begin
                        m_err = 1'b1;
                    end
                end
                if (start) begin
                    m_run = 1;
                    m_n   = 0;
                    m_len = (int'(len) < DEPTH) ? int'(len) : DEPTH;
                end
            end else begin
                if (wr_en) m_err = 1'b1;
                if (m_n >= LANES + m_len) begin
                    if (array_done) m_run = 0;
                end else begin
                    m_n++;
                end
            end
        end
    endtask

    task automatic check_out();
        logic [BW-1:0]    ea, ew;
        logic [LANES-1:0] ed;
        logic             ee;
        int               k;
        ea = '0;
        ew = '0;
        ed = '0;
        if (m_run != 0) begin
            for (int i = 0; i < LANES; i++) begin
                k = m_n - 1 - i;
                if (k >= 0 && k < m_len) begin
                    ea[i*DW +: DW] = m_act[i][k];
                    ew[i*DW +: DW] = m_wgt[i][k];
                end
                ed[i] = (m_n >= 1 + i + m_len);
            end
        end
`ifdef SKEW_FEEDER_OVERRUN_EN
        ee = m_err;
`else
        ee = 1'b0;
`endif
        chk("activations", activations, ea);
        chk("weights", weights, ew);
        chk("done", BW'(done), BW'(ed));
        chk("busy", BW'(busy), BW'(m_run != 0));
        chk("wr_err", BW'(wr_err), BW'(ee));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_out();
    endtask

    task automatic idle_in();
        rst        = 1'b0;
        en         = 1'b1;
        wr_en      = 1'b0;
        start      = 1'b0;
        array_done = 1'b0;
    endtask

    task automatic wr(input int l, input int k,
                      input logic [DW-1:0] a, input logic [DW-1:0] w);
        wr_en   = 1'b1;
        wr_lane = 3'(l);
        wr_idx  = 4'(k);
        wr_act  = a;
        wr_wgt  = w;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic go(input int l);
        start = 1'b1;
        len   = 4'(l);
        step();
        start = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic release_wait();
        array_done = 1'b1;
        step();
        array_done = 1'b0;
        step();
    endtask

    initial begin
        m_run = 0;
        m_n   = 0;
        m_len = 0;
        m_err = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                m_act[i][k] = '0;
                m_wgt[i][k] = '0;
            end
        end
        idle_in();
        wr_lane = '0;
        wr_idx  = '0;
        wr_act  = '0;
        wr_wgt  = '0;
        len     = '0;

        // reset state
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        step();

        // diagonal pattern load, plus out-of-range writes
        for (int i = 0; i < LANES; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                wr(i, k, DW'(32'h100 * i + k), DW'(32'h200 * i + k));
            end
        end
        wr(2, 4, 16'hffff, 16'hffff);
        wr(5, 9, 16'hffff, 16'hffff);
        step();

        // len=4 tile, array_done during FEED must be ignored
        go(4);
        run(5);
        array_done = 1'b1;
        step();
        array_done = 1'b0;
        run(8);
        release_wait();

        // replay with start alone
        go(4);
        run(14);
        release_wait();

        // len=0 and len clamp
        go(0);
        run(10);
        release_wait();
        go(9);
        run(14);
        release_wait();

        // 3-cycle stall mid-stream, start ignored while busy
        go(4);
        run(4);
        en = 1'b0;
        run(3);
        en = 1'b1;
        start = 1'b1;
        len   = 4'd1;
        step();
        start = 1'b0;
        run(12);
        release_wait();

        // reset mid-stream, then replay old data
        go(4);
        run(5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(2);
        go(4);
        run(14);
        release_wait();

        // write during FEED must not alter buffers
        go(3);
        run(2);
        wr(1, 1, 16'hdead, 16'hbeef);
        run(12);
        release_wait();
        go(4);
        run(14);
        release_wait();

        // randomized traffic
        repeat (2500) begin
            rst        = ($urandom_range(0, 199) == 0);
            en         = ($urandom_range(0, 9) != 0);
            wr_en      = ($urandom_range(0, 2) == 0);
            wr_lane    = 3'($urandom_range(0, LANES - 1));
            wr_idx     = ($urandom_range(0, 4) == 0) ?
                         4'($urandom_range(0, 15)) :
                         4'($urandom_range(0, DEPTH - 1));
            wr_act     = DW'($urandom);
            wr_wgt     = DW'($urandom);
            start      = ($urandom_range(0, 5) == 0);
            len        = ($urandom_range(0, 3) == 0) ?
                         4'($urandom_range(0, 15)) :
                         4'($urandom_range(0, DEPTH));
            array_done = ($urandom_range(0, 3) == 0);
            step();
        end
        idle_in();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
